// File: rtl/rob_fill_responder.sv
// rob_fill_responder: ROB-side responder for the reservation-station fill protocol.
// Round-robin arbitration over N_REQ requesters feeds a one-entry holding register.
// The register writes into the ROB data array and sets the entry's done bit.
// Optional feature macro: ROB_FILL_BYPASS_EN. When defined, every ROB write is also
// broadcast on bcast_* for operand wakeup. Otherwise bcast_* are tied to zero.
module rob_fill_responder #(
    parameter int N_REQ     = 4,
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               fill_valid,
    input  logic [N_REQ*ROB_IDX_W-1:0]     fill_idx,
    input  logic [N_REQ*DATA_W-1:0]        fill_data,
    output logic [N_REQ-1:0]               fill_ready,
    input  logic                           rob_wr_stall,
    output logic                           rob_wr_en,
    output logic [ROB_IDX_W-1:0]           rob_wr_idx,
    output logic [DATA_W-1:0]              rob_wr_data,
    input  logic                           alloc_en,
    input  logic [ROB_IDX_W-1:0]           alloc_idx,
    input  logic                           flush,
    input  logic [ROB_IDX_W-1:0]           head_idx,
    output logic                           head_done,
    output logic                           dup_err,
    output logic                           bcast_valid,
    output logic [ROB_IDX_W-1:0]           bcast_idx,
    output logic [DATA_W-1:0]              bcast_data
);

    localparam int DEPTH = 1 << ROB_IDX_W;
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } hold_state_t;

    hold_state_t            state_q;
    hold_state_t            state_d;
    logic [ROB_IDX_W-1:0]   hold_idx_q;
    logic [DATA_W-1:0]      hold_data_q;
    logic [PTR_W-1:0]       rr_q;
    logic [PTR_W-1:0]       rr_d;
    logic [PTR_W-1:0]       rr_next;
    logic [DEPTH-1:0]       done_q;
    logic                   dup_q;

    logic [N_REQ-1:0]       grant_vec;
    logic                   grant_any;
    logic [ROB_IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]      sel_data;
    logic                   wr_en;
    logic                   grant_ok;
    logic                   take;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_vec = '0;
        grant_any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!grant_any && (i == (int'(rr_q) + k) % N_REQ) && fill_valid[i]) begin
                    grant_vec[i] = 1'b1;
                    grant_any    = 1'b1;
                end
            end
        end
    end

    // Select the winner's payload and the pointer value that follows it.
    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        rr_next  = rr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_vec[i]) begin
                sel_idx  = fill_idx[i*ROB_IDX_W +: ROB_IDX_W];
                sel_data = fill_data[i*DATA_W +: DATA_W];
                rr_next  = PTR_W'((i + 1) % N_REQ);
            end
        end
    end

    // Holding-register next state, grant gating and write strobe; flush overrides all.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        wr_en      = (state_q == HOLD_FULL) && !rob_wr_stall && !flush;
        grant_ok   = !flush && ((state_q == HOLD_EMPTY) || !rob_wr_stall);
        take       = grant_ok && grant_any;
        fill_ready = grant_ok ? grant_vec : '0;
        if (flush) begin
            state_d = HOLD_EMPTY;
        end else if (take) begin
            state_d = HOLD_FULL;
            rr_d    = rr_next;
        end else if (wr_en) begin
            state_d = HOLD_EMPTY;
        end
    end

    // State, pointer and captured payload registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HOLD_EMPTY;
            rr_q        <= '0;
            hold_idx_q  <= '0;
            hold_data_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (take) begin
                hold_idx_q  <= sel_idx;
                hold_data_q <= sel_data;
            end
        end
    end

    // Done bitmap and sticky duplicate-fill flag; allocation beats a same-index write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= '0;
            dup_q  <= 1'b0;
        end else if (flush) begin
            done_q <= '0;
        end else begin
            if (wr_en) begin
                done_q[hold_idx_q] <= 1'b1;
                if (done_q[hold_idx_q]) begin
                    dup_q <= 1'b1;
                end
            end
            if (alloc_en) begin
                done_q[alloc_idx] <= 1'b0;
            end
        end
    end

    assign rob_wr_en   = wr_en;
    assign rob_wr_idx  = hold_idx_q;
    assign rob_wr_data = hold_data_q;
    assign head_done   = done_q[head_idx];
    assign dup_err     = dup_q;

`ifdef ROB_FILL_BYPASS_EN
    assign bcast_valid = wr_en;
    assign bcast_idx   = hold_idx_q;
    assign bcast_data  = hold_data_q;
`else
    assign bcast_valid = 1'b0;
    assign bcast_idx   = '0;
    assign bcast_data  = '0;
`endif

endmodule

// File: tb/tb_rob_fill_responder.sv
// tb_rob_fill_responder: self-checking bench for rob_fill_responder.
// Table-driven vectors, hand-written corner sequences, then randomized traffic
// against a behavioural model. Honours ROB_FILL_BYPASS_EN for the bcast_* outputs.
module tb_rob_fill_responder;

    localparam int N  = 4;
    localparam int IW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      fill_valid;
    logic [N*IW-1:0]   fill_idx;
    logic [N*DW-1:0]   fill_data;
    logic [N-1:0]      fill_ready;
    logic              rob_wr_stall;
    logic              rob_wr_en;
    logic [IW-1:0]     rob_wr_idx;
    logic [DW-1:0]     rob_wr_data;
    logic              alloc_en;
    logic [IW-1:0]     alloc_idx;
    logic              flush;
    logic [IW-1:0]     head_idx;
    logic              head_done;
    logic              dup_err;
    logic              bcast_valid;
    logic [IW-1:0]     bcast_idx;
    logic [DW-1:0]     bcast_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IW-1:0] req_idx  [N];
    logic [DW-1:0] req_data [N];

    typedef struct {
        logic [3:0]  valid;
        logic [4:0]  head;
        logic [3:0]  exp_ready;
        logic        exp_wr;
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
        logic        exp_hd;
        logic        exp_dup;
    } vec_t;

    vec_t tbl [12];

    rob_fill_responder #(.N_REQ(N), .ROB_IDX_W(IW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
        .fill_ready(fill_ready), .rob_wr_stall(rob_wr_stall),
        .rob_wr_en(rob_wr_en), .rob_wr_idx(rob_wr_idx), .rob_wr_data(rob_wr_data),
        .alloc_en(alloc_en), .alloc_idx(alloc_idx), .flush(flush),
        .head_idx(head_idx), .head_done(head_done), .dup_err(dup_err),
        .bcast_valid(bcast_valid), .bcast_idx(bcast_idx), .bcast_data(bcast_data)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // One comparison: counts it, reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Sets a requester's payload; it reaches the pins at the next applyStimulus.
    task automatic setReq(input int i, input logic [IW-1:0] idx, input logic [DW-1:0] data);
        req_idx[i]  = idx;
        req_data[i] = data;
    endtask

    // Drives one cycle of inputs just after a rising edge and waits for the falling edge.
    task automatic applyStimulus(input logic [3:0] v, input logic st, input logic ae,
                                 input logic [4:0] ai, input logic fl, input logic [4:0] hd);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            fill_idx[i*IW +: IW]  = req_idx[i];
            fill_data[i*DW +: DW] = req_data[i];
        end
        fill_valid   = v;
        rob_wr_stall = st;
        alloc_en     = ae;
        alloc_idx    = ai;
        flush        = fl;
        head_idx     = hd;
        @(negedge clk);
    endtask

    // Checks the write port and the broadcast port against an expected write.
    task automatic checkWrite(input string name, input logic ew, input logic [4:0] ei, input logic [31:0] ed);
        checkOutput({name, ".wr_en"}, 32'(rob_wr_en), 32'(ew));
        if (ew) begin
            checkOutput({name, ".wr_idx"}, 32'(rob_wr_idx), 32'(ei));
            checkOutput({name, ".wr_data"}, rob_wr_data, ed);
        end
`ifdef ROB_FILL_BYPASS_EN
        checkOutput({name, ".bcast_valid"}, 32'(bcast_valid), 32'(ew));
        if (ew) begin
            checkOutput({name, ".bcast_idx"}, 32'(bcast_idx), 32'(ei));
            checkOutput({name, ".bcast_data"}, bcast_data, ed);
        end
`else
        checkOutput({name, ".bcast_valid"}, 32'(bcast_valid), 32'd0);
        checkOutput({name, ".bcast_idx"}, 32'(bcast_idx), 32'd0);
        checkOutput({name, ".bcast_data"}, bcast_data, 32'd0);
`endif
    endtask

    // Ready plus write-port checks for one hand-written cycle.
    task automatic checkCycle(input string name, input logic [3:0] er, input logic ew,
                              input logic [4:0] ei, input logic [31:0] ed);
        checkOutput({name, ".ready"}, 32'(fill_ready), 32'(er));
        checkWrite(name, ew, ei, ed);
    endtask

    // Synchronous reset with idle inputs.
    task automatic doReset();
        rst_n        = 1'b0;
        fill_valid   = '0;
        rob_wr_stall = 1'b0;
        alloc_en     = 1'b0;
        alloc_idx    = '0;
        flush        = 1'b0;
        head_idx     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Walks every head index with idle inputs and expects all done bits clear.
    task automatic checkAllClear(input string name);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'(i));
            checkOutput($sformatf("%s.done%0d", name, i), 32'(head_done), 32'd0);
        end
    endtask

    // Randomized traffic checked against a transaction-level model of the responder.
    task automatic runRandom(input int cycles);
        bit            m_full = 0;
        logic [4:0]    m_idx  = '0;
        logic [31:0]   m_data = '0;
        int            m_rr   = 0;
        bit            m_done [32];
        bit            m_dup  = 0;
        logic [3:0]    pend   = '0;
        for (int i = 0; i < 32; i++) m_done[i] = 0;
        for (int c = 0; c < cycles; c++) begin
            logic        st, ae, fl, e_wr;
            logic [4:0]  ai, hd;
            logic [3:0]  e_ready;
            int          gj;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 9) < 4)) begin
                    pend[i] = 1'b1;
                    setReq(i, 5'($urandom_range(0, 31)), $urandom);
                end
            end
            st = ($urandom_range(0, 3) == 0);
            ae = ($urandom_range(0, 4) == 0);
            ai = 5'($urandom_range(0, 31));
            fl = ($urandom_range(0, 39) == 0);
            hd = 5'($urandom_range(0, 31));
            applyStimulus(pend, st, ae, ai, fl, hd);
            e_wr    = m_full && !st && !fl;
            e_ready = '0;
            gj      = -1;
            if (!fl && !(m_full && st)) begin
                for (int k = 0; k < N; k++) begin
                    if (pend[(m_rr + k) % N]) begin
                        gj = (m_rr + k) % N;
                        break;
                    end
                end
            end
            if (gj >= 0) e_ready[gj] = 1'b1;
            checkOutput($sformatf("rnd%0d.ready", c), 32'(fill_ready), 32'(e_ready));
            checkWrite($sformatf("rnd%0d", c), e_wr, m_idx, m_data);
            checkOutput($sformatf("rnd%0d.head_done", c), 32'(head_done), 32'(m_done[hd]));
            checkOutput($sformatf("rnd%0d.dup_err", c), 32'(dup_err), 32'(m_dup));
            if (fl) begin
                m_full = 0;
                for (int i = 0; i < 32; i++) m_done[i] = 0;
            end else begin
                if (e_wr) begin
                    if (m_done[m_idx]) m_dup = 1;
                    m_done[m_idx] = 1;
                end
                if (ae) m_done[ai] = 0;
                if (gj >= 0) begin
                    m_full   = 1;
                    m_idx    = req_idx[gj];
                    m_data   = req_data[gj];
                    m_rr     = (gj + 1) % N;
                    pend[gj] = 1'b0;
                end else if (e_wr) begin
                    m_full = 0;
                end
            end
        end
    endtask

    // Main sequence: table vectors, corner sequences, random traffic, summary.
    initial begin
        fill_idx  = '0;
        fill_data = '0;
        for (int i = 0; i < N; i++) setReq(i, '0, '0);

        tbl[0]  = '{4'b0000, 5'd0,  4'b0000, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        tbl[1]  = '{4'b0100, 5'd7,  4'b0100, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        tbl[2]  = '{4'b0000, 5'd7,  4'b0000, 1'b1, 5'd7,  32'hDEADBEEF,  1'b0, 1'b0};
        tbl[3]  = '{4'b0000, 5'd7,  4'b0000, 1'b0, 5'd0,  32'h0,         1'b1, 1'b0};
        tbl[4]  = '{4'b1000, 5'd0,  4'b1000, 1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        tbl[5]  = '{4'b1111, 5'd13, 4'b0001, 1'b1, 5'd13, 32'hD3D30004,  1'b0, 1'b0};
        tbl[6]  = '{4'b1111, 5'd13, 4'b0010, 1'b1, 5'd10, 32'hA0A00001,  1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 5'd10, 4'b0100, 1'b1, 5'd11, 32'hB1B10002,  1'b1, 1'b0};
        tbl[8]  = '{4'b1111, 5'd11, 4'b1000, 1'b1, 5'd7,  32'hDEADBEEF,  1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 5'd7,  4'b0001, 1'b1, 5'd13, 32'hD3D30004,  1'b1, 1'b1};
        tbl[10] = '{4'b0000, 5'd13, 4'b0000, 1'b1, 5'd10, 32'hA0A00001,  1'b1, 1'b1};
        tbl[11] = '{4'b0000, 5'd10, 4'b0000, 1'b0, 5'd0,  32'h0,         1'b1, 1'b1};

        doReset();
        setReq(0, 5'd10, 32'hA0A00001);
        setReq(1, 5'd11, 32'hB1B10002);
        setReq(2, 5'd7,  32'hDEADBEEF);
        setReq(3, 5'd13, 32'hD3D30004);
        for (int r = 0; r < 12; r++) begin
            applyStimulus(tbl[r].valid, 1'b0, 1'b0, 5'd0, 1'b0, tbl[r].head);
            if (r == 0) begin
                checkOutput("reset.wr_idx", 32'(rob_wr_idx), 32'd0);
                checkOutput("reset.wr_data", rob_wr_data, 32'd0);
            end
            checkOutput($sformatf("tbl%0d.ready", r), 32'(fill_ready), 32'(tbl[r].exp_ready));
            checkWrite($sformatf("tbl%0d", r), tbl[r].exp_wr, tbl[r].exp_idx, tbl[r].exp_data);
            checkOutput($sformatf("tbl%0d.head_done", r), 32'(head_done), 32'(tbl[r].exp_hd));
            checkOutput($sformatf("tbl%0d.dup_err", r), 32'(dup_err), 32'(tbl[r].exp_dup));
        end

        // Stall: holding register full with idx 3 while requester 1 waits.
        doReset();
        setReq(0, 5'd3, 32'h33333333);
        setReq(1, 5'd20, 32'h14141414);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("stall.fill", 4'b0001, 1'b0, 5'd0, 32'h0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("stall.c1", 4'b0000, 1'b0, 5'd0, 32'h0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("stall.c2", 4'b0000, 1'b0, 5'd0, 32'h0);
        applyStimulus(4'b0010, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("stall.drop", 4'b0010, 1'b1, 5'd3, 32'h33333333);
        applyStimulus(4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("stall.after", 4'b0000, 1'b1, 5'd20, 32'h14141414);

        // Collision: alloc of 9 in the write cycle of 9, then repeated fills of 9.
        setReq(0, 5'd9, 32'h99990001);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("coll.fill1", 4'b0001, 1'b0, 5'd0, 32'h0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0);
        checkCycle("coll.wr1", 4'b0000, 1'b1, 5'd9, 32'h99990001);
        applyStimulus(4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9);
        checkOutput("coll.done9_alloc_wins", 32'(head_done), 32'd0);
        checkOutput("coll.dup_after1", 32'(dup_err), 32'd0);
        setReq(0, 5'd9, 32'h99990002);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9);
        checkCycle("coll.fill2", 4'b0001, 1'b0, 5'd0, 32'h0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9);
        checkCycle("coll.wr2", 4'b0000, 1'b1, 5'd9, 32'h99990002);
        checkOutput("coll.no_bypass", 32'(head_done), 32'd0);
        setReq(0, 5'd9, 32'h99990003);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9);
        checkCycle("coll.fill3", 4'b0001, 1'b0, 5'd0, 32'h0);
        checkOutput("coll.done9_set", 32'(head_done), 32'd1);
        checkOutput("coll.dup_after2", 32'(dup_err), 32'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9);
        checkCycle("coll.wr3", 4'b0000, 1'b1, 5'd9, 32'h99990003);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9);
            checkOutput($sformatf("coll.dup_sticky%0d", i), 32'(dup_err), 32'd1);
        end

        // Flush while full with idx 5: no write, no grant, done bitmap cleared.
        setReq(0, 5'd5, 32'h55555555);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("flush.fill", 4'b0001, 1'b0, 5'd0, 32'h0);
        setReq(0, 5'd8, 32'h88888888);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0);
        checkCycle("flush.cycle", 4'b0000, 1'b0, 5'd0, 32'h0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("flush.after", 4'b0000, 1'b0, 5'd0, 32'h0);
        checkOutput("flush.dup_kept", 32'(dup_err), 32'd1);
        checkAllClear("flush");

        // Reset mid-operation with the holding register full.
        setReq(0, 5'd6, 32'h66666666);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("rst.fill1", 4'b0001, 1'b0, 5'd0, 32'h0);
        setReq(0, 5'd12, 32'hCCCCCCCC);
        applyStimulus(4'b0001, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkCycle("rst.wr1", 4'b0001, 1'b1, 5'd6, 32'h66666666);
        applyStimulus(4'b0000, 1'b1, 1'b0, 5'd0, 1'b0, 5'd6);
        checkCycle("rst.full", 4'b0000, 1'b0, 5'd0, 32'h0);
        checkOutput("rst.done6_before", 32'(head_done), 32'd1);
        checkOutput("rst.dup_before", 32'(dup_err), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd6);
        checkCycle("rst.after", 4'b0000, 1'b0, 5'd0, 32'h0);
        checkOutput("rst.wr_idx", 32'(rob_wr_idx), 32'd0);
        checkOutput("rst.wr_data", rob_wr_data, 32'd0);
        checkOutput("rst.done6", 32'(head_done), 32'd0);
        checkOutput("rst.dup", 32'(dup_err), 32'd0);
        checkAllClear("rst");

        doReset();
        for (int i = 0; i < N; i++) setReq(i, '0, '0);
        runRandom(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
